// File: rtl/epu_pkg.sv
// Shared types and defaults for the EPU convolution datapath blocks.
package epu_pkg;

  typedef enum logic [1:0] {IDLE, FILL, COL, READY} win_state_e;

  localparam int DW_DEF   = 8;
  localparam int KMAX_DEF = 5;

  // Kernel edges of 0 or beyond the physical array fall back to the full array.
  function automatic int clamp_ksize(input int ksize, input int kmax);
    return (ksize < 1 || ksize > kmax) ? kmax : ksize;
  endfunction

endpackage

// File: rtl/window_buf.sv
// KxK sliding-window pixel buffer: column-major fill, single-column refill and
// left shift, presenting the whole window in parallel to the PE array.
//
//   state | meaning
//   IDLE  | no valid window
//   FILL  | full-window load in progress
//   COL   | single-column load into column K-1 in progress
//   READY | window complete, o_win_valid high
module window_buf
  import epu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int KMAX = KMAX_DEF,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KW-1:0]          i_ksize,
  input  logic                   i_start_full,
  input  logic                   i_start_col,
  input  logic                   i_shift,
  input  logic                   i_clear,
  input  logic                   i_px_valid,
  input  logic [DW-1:0]          i_px,
  output logic                   o_px_ready,
  output logic [KMAX*KMAX*DW-1:0] o_win,
  output logic                   o_win_valid,
  output logic                   o_busy
);

  win_state_e state_q, state_d;
  logic [DW-1:0] win [KMAX][KMAX];
  logic [KW-1:0] row, col, ksize_q, klast;
  logic          accept;
  int            kq;

  assign klast  = ksize_q - KW'(1);
  assign kq     = int'(ksize_q);
  assign accept = i_px_valid && o_px_ready;

  assign o_px_ready  = (state_q == FILL) || (state_q == COL);
  assign o_busy      = (state_q == FILL) || (state_q == COL);
  assign o_win_valid = (state_q == READY);

  always_comb begin
    o_win = '0;
    for (int r = 0; r < KMAX; r++)
      for (int c = 0; c < KMAX; c++)
        o_win[(r*KMAX+c)*DW +: DW] = win[r][c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start_full)     state_d = FILL;
          else if (i_start_col) state_d = COL;
        end
        READY: begin
          if (i_start_full)     state_d = FILL;
          else if (i_start_col) state_d = COL;
          else if (i_shift)     state_d = IDLE;
        end
        FILL: if (accept && row == klast && col == klast) state_d = READY;
        COL:  if (accept && row == klast) state_d = READY;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KMAX; r++)
        for (int c = 0; c < KMAX; c++)
          win[r][c] <= '0;
      row     <= '0;
      col     <= '0;
      ksize_q <= KW'(KMAX);
    end else if (i_clear) begin
      for (int r = 0; r < KMAX; r++)
        for (int c = 0; c < KMAX; c++)
          win[r][c] <= '0;
      row <= '0;
      col <= '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (i_start_full) begin
            for (int r = 0; r < KMAX; r++)
              for (int c = 0; c < KMAX; c++)
                win[r][c] <= '0;
            row     <= '0;
            col     <= '0;
            ksize_q <= KW'(clamp_ksize(int'(i_ksize), KMAX));
          end else if (i_start_col) begin
            row <= '0;
          end else if (i_shift && state_q == READY) begin
            // Outside the active KxK region nothing moves, so it stays zero.
            for (int r = 0; r < KMAX; r++) begin
              if (r < kq) begin
                for (int c = 0; c < KMAX - 1; c++)
                  if (c < kq - 1) win[r][c] <= win[r][c+1];
                win[r][klast] <= '0;
              end
            end
          end
        end
        FILL: begin
          if (accept) begin
            win[row][col] <= i_px;
            if (row == klast) begin
              row <= '0;
              col <= col + KW'(1);
            end else begin
              row <= row + KW'(1);
            end
          end
        end
        COL: begin
          if (accept) begin
            win[row][klast] <= i_px;
            row <= row + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
